// File: rtl/store_port_arbiter.sv
// Round-robin arbiter funnelling several store requesters onto the single D$ store port.
// Once a request is shown to the D$ it stays locked until the D$ accepts it.
module store_port_arbiter #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned ADDR_W   = 56,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_PORTS-1:0]                  req_i,
  input  logic [NR_PORTS-1:0][ADDR_W-1:0]      addr_i,
  input  logic [NR_PORTS-1:0][DATA_W-1:0]      data_i,
  input  logic [NR_PORTS-1:0][DATA_W/8-1:0]    be_i,
  input  logic [NR_PORTS-1:0][1:0]             size_i,
  output logic [NR_PORTS-1:0]                  gnt_o,
  output logic                                 req_o,
  output logic [ADDR_W-1:0]                    addr_o,
  output logic [DATA_W-1:0]                    data_o,
  output logic [DATA_W/8-1:0]                  be_o,
  output logic [1:0]                           size_o,
  input  logic                                 gnt_i,
  output logic                                 busy_o
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e state_q, state_d;
  idx_t   rr_q, rr_d;
  idx_t   idx_q, idx_d;

  logic   w_found;
  idx_t   w_cand;
  idx_t   w_scan_sel;
  idx_t   w_sel;
  logic   w_req;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NR_PORTS - 1)) ? '0 : idx_t'(i + 1'b1);
  endfunction

  // Priority scan starting at rr_q and wrapping past the last requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_found    = 1'b0;
    w_cand     = '0;
    w_scan_sel = rr_q;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      w_cand = idx_t'((32'(rr_q) + k) % NR_PORTS);
      if (!w_found && req_i[w_cand]) begin
        w_found    = 1'b1;
        w_scan_sel = w_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    gnt_o   = '0;
    w_req   = 1'b0;
    w_sel   = w_scan_sel;
    // Outputs stay quiet for the whole reset window, not just after the flops clear.
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          if (!flush_i && w_found) begin
            w_req = 1'b1;
            if (gnt_i) begin
              gnt_o[w_scan_sel] = 1'b1;
              rr_d              = next_idx(w_scan_sel);
            end else begin
              state_d = LOCKED;
              idx_d   = w_scan_sel;
            end
          end
        end
        LOCKED: begin
          w_req = 1'b1;
          w_sel = idx_q;
          if (gnt_i) begin
            gnt_o[idx_q] = 1'b1;
            rr_d         = next_idx(idx_q);
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
    end
  end

  assign req_o  = w_req;
  assign addr_o = addr_i[w_sel];
  assign data_o = data_i[w_sel];
  assign be_o   = be_i[w_sel];
  assign size_o = size_i[w_sel];
  assign busy_o = rst_ni && (state_q == LOCKED);

`ifndef SYNTHESIS
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> req_i[idx_q]);
  a_gnt_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o) && ((gnt_o == '0) || gnt_i));
  a_no_revoke: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_o && !gnt_i) |=> (req_o && $stable(addr_o) && $stable(data_o)
                           && $stable(be_o) && $stable(size_o)));
`endif

endmodule
